// File: rtl/raven_uart_pkg.sv
// Shared types and constants for the Raven UART transmitter.
// RAVEN_UART_TX_PARITY_EN adds an even-parity bit (PARITY state) after the data bits.
package raven_uart_pkg;

`ifdef RAVEN_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;
  localparam int unsigned FRAME_BITS = 11;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;
  localparam int unsigned FRAME_BITS = 10;
`endif

  localparam logic [15:0] DIV_MIN       = 16'd4;
  localparam int unsigned DATA_BITS     = 8;
  localparam logic [2:0]  LAST_DATA_BIT = 3'(DATA_BITS - 1);

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/raven_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; DEPTH must be a power of two.
module raven_uart_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // Full refuses the push even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level <= level + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/raven_uart_tx.sv
// Buffered 8N1 UART transmitter: CPU bytes queue in a FIFO and are serialised LSB-first on ser_tx.
// RAVEN_UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module raven_uart_tx
  import raven_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reg_div_we,
  input  logic [15:0]                   reg_div_di,
  output logic [15:0]                   reg_div_do,
  input  logic                          reg_dat_we,
  input  logic [7:0]                    reg_dat_di,
  output logic                          reg_dat_wait,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          ser_tx
);

  tx_state_t   state, state_n;
  logic [15:0] div;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shifter, shift_n;
  logic        line;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        bit_end;
`ifdef RAVEN_UART_TX_PARITY_EN
  logic        parity, parity_n;
`endif

  raven_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (reg_dat_we),
    .din   (reg_dat_di),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign reg_dat_wait = reg_dat_we & fifo_full;
  assign reg_div_do   = div;
  assign busy         = (state != ST_IDLE) | ~fifo_empty;
  assign bit_end      = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= clamp_div(DIV_RESET);
    end else if (reg_div_we) begin
      div <= clamp_div(reg_div_di);
    end
  end

  // The period is sampled into baud_cnt at each bit boundary, so a divider write never stretches the active bit.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shifter;
    pop     = 1'b0;
    line    = 1'b1;
`ifdef RAVEN_UART_TX_PARITY_EN
    parity_n = parity;
`endif
    case (state)
      ST_IDLE: begin
        line = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          baud_n  = div - 16'd1;
          state_n = ST_START;
`ifdef RAVEN_UART_TX_PARITY_EN
          parity_n = ^fifo_dout;
`endif
        end
      end
      ST_START: begin
        line = 1'b0;
        if (bit_end) begin
          baud_n  = div - 16'd1;
          bit_n   = '0;
          state_n = ST_DATA;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      ST_DATA: begin
        line = shifter[0];
        if (bit_end) begin
          baud_n  = div - 16'd1;
          shift_n = {1'b0, shifter[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == LAST_DATA_BIT) begin
`ifdef RAVEN_UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
`ifdef RAVEN_UART_TX_PARITY_EN
      ST_PARITY: begin
        line = parity;
        if (bit_end) begin
          baud_n  = div - 16'd1;
          state_n = ST_STOP;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        line = 1'b1;
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            baud_n  = div - 16'd1;
            state_n = ST_START;
`ifdef RAVEN_UART_TX_PARITY_EN
            parity_n = ^fifo_dout;
`endif
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      ser_tx   <= 1'b1;
`ifdef RAVEN_UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shifter  <= shift_n;
      ser_tx   <= line;
`ifdef RAVEN_UART_TX_PARITY_EN
      parity   <= parity_n;
`endif
    end
  end

endmodule
